// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter/sequencer in front of the single-ported data memory.
// Port 0 = CPU load/store unit, port 1 = debug/DMA master.
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   reqN/weN/addrN/wdataN/maskN   request + payload, held until gntN
//   gntN                     combinational grant, high in the issue cycle
//   rvalidN / wdoneN         one-cycle load-data-valid / store-done pulses
//   rdata                    shared load data, qualified by rvalidN
//   busy                     an access is in flight
//   mem_*                    memory side (addr, write_data, memread,
//                            memwrite, sign_mask, read_data, clk_stall)
module dmem_port_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  input  logic [3:0]  mask0,
  input  logic [3:0]  mask1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic        wdone0,
  output logic        wdone1,
  output logic [31:0] rdata,
  output logic        busy,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_memread,
  output logic        mem_memwrite,
  output logic [3:0]  mem_sign_mask,
  input  logic [31:0] mem_read_data,
  input  logic        mem_clk_stall
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    READ_WAIT  = 2'd1,
    WRITE_WAIT = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   owner_q, owner_d;
  logic   last_grant_q, last_grant_d;
  // Set for the first WRITE_WAIT cycle: the memory raises clk_stall
  // only after it has seen memwrite, so stall is ignored there.
  logic   wfirst_q, wfirst_d;

  logic        any_req;
  logic        win;
  logic        w_we;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic [3:0]  w_mask;
  logic        ww_done;

  assign any_req = req0 | req1;

  // Tie-break: fixed priority to port 0, or the port not granted last.
  always_comb begin
    if (req0 && req1) begin
      win = FIXED_PRIO ? 1'b0 : ~last_grant_q;
    end else begin
      win = req1;
    end
  end

  assign w_we    = win ? we1    : we0;
  assign w_addr  = win ? addr1  : addr0;
  assign w_wdata = win ? wdata1 : wdata0;
  assign w_mask  = win ? mask1  : mask0;

  assign ww_done = (state_q == WRITE_WAIT) && !wfirst_q && !mem_clk_stall;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      wfirst_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      wfirst_q     <= wfirst_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    wfirst_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d      = w_we ? WRITE_WAIT : READ_WAIT;
          owner_d      = win;
          last_grant_d = win;
          wfirst_d     = w_we;
        end
      end
      READ_WAIT: begin
        state_d = IDLE;
      end
      WRITE_WAIT: begin
        if (ww_done) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output logic; everything is forced low while reset is high.
  always_comb begin
    gnt0           = 1'b0;
    gnt1           = 1'b0;
    rvalid0        = 1'b0;
    rvalid1        = 1'b0;
    wdone0         = 1'b0;
    wdone1         = 1'b0;
    rdata          = 32'h0;
    busy           = 1'b0;
    mem_addr       = 32'h0;
    mem_write_data = 32'h0;
    mem_memread    = 1'b0;
    mem_memwrite   = 1'b0;
    mem_sign_mask  = 4'h0;
    if (!reset) begin
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            gnt0           = ~win;
            gnt1           = win;
            mem_addr       = w_addr;
            mem_write_data = w_wdata;
            mem_sign_mask  = w_mask;
            mem_memread    = ~w_we;
            mem_memwrite   = w_we;
          end
        end
        READ_WAIT: begin
          busy    = 1'b1;
          rdata   = mem_read_data;
          rvalid0 = ~owner_q;
          rvalid1 = owner_q;
        end
        WRITE_WAIT: begin
          busy = 1'b1;
          if (ww_done) begin
            wdone0 = ~owner_q;
            wdone1 = owner_q;
          end
        end
        default: begin
          busy = 1'b0;
        end
      endcase
    end
  end

endmodule
